// File: rtl/sym_unpack.sv
// sym_unpack: receive-side symbol-to-bit unpacker.
// 4-bit (16-QAM) / 2-bit (QPSK) symbols in, LSB-first serial bits out.
module sym_unpack (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic [3:0] DAT_I,
  output logic       ACK_O,
  input  logic       QAM,
  input  logic       QPSK,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  output logic       DAT_O,
  input  logic       ACK_I,
  output logic       LAST_O
);

  logic [3:0] sh;
  logic [2:0] rem;
  logic [3:0] hold;
  logic [2:0] hold_len;
  logic       hold_valid;
  logic       cyc_q;

  logic       mode_ok;
  logic [2:0] len;
  logic [3:0] sym;
  logic       accept;
  logic       busy;
  logic       xfer;
  logic       load;

  assign mode_ok = QAM | QPSK;
  assign len     = QAM ? 3'd4 : 3'd2;

  // unused QPSK bits are zeroed so the shifter drains clean
  assign sym     = QAM ? DAT_I : {2'b00, DAT_I[1:0]};

  assign accept  = CYC_I & STB_I & WE_I & mode_ok & ~hold_valid;
  assign busy    = (rem != 3'd0);
  assign xfer    = busy & ACK_I;
  assign load    = hold_valid &
                   ((rem == 3'd0) | ((rem == 3'd1) & xfer));

  assign ACK_O  = accept;
  assign STB_O  = busy;
  assign WE_O   = busy;
  assign DAT_O  = sh[0];
  assign LAST_O = (rem == 3'd1);
  assign CYC_O  = cyc_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sh  <= 4'd0;
      rem <= 3'd0;
    end else if (load) begin
      sh  <= hold;
      rem <= hold_len;
    end else if (xfer) begin
      sh  <= {1'b0, sh[3:1]};
      rem <= rem - 3'd1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      hold       <= 4'd0;
      hold_len   <= 3'd0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold       <= sym;
      hold_len   <= len;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // bus cycle stays open until every buffered bit has drained
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) cyc_q <= 1'b0;
    else        cyc_q <= CYC_I | hold_valid | busy;
  end

endmodule

// File: tb/tb_sym_unpack.sv
// tb_sym_unpack: directed + random checks of sym_unpack
// against a queue-based bit-stream model.
module tb_sym_unpack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc_i, stb_i, we_i;
  logic [3:0] dat_i;
  logic       ack_o;
  logic       qam, qpsk;
  logic       cyc_o, stb_o, we_o, dat_o;
  logic       ack_i;
  logic       last_o;

  sym_unpack dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .CYC_I (cyc_i),
    .STB_I (stb_i),
    .WE_I  (we_i),
    .DAT_I (dat_i),
    .ACK_O (ack_o),
    .QAM   (qam),
    .QPSK  (qpsk),
    .CYC_O (cyc_o),
    .STB_O (stb_o),
    .WE_O  (we_o),
    .DAT_O (dat_o),
    .ACK_I (ack_i),
    .LAST_O(last_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: bits of the symbol being sent, plus one waiting symbol
  bit cur[$];
  bit bufq[$];
  bit have_buf;
  bit exp_cyc;

  bit got[$];
  bit gotl[$];
  bit last_stb, last_ack, last_dat, prev_stb;
  int stb_edges;

  task automatic chk(string tag, logic [15:0] obs,
                     logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] vec(bit q[$]);
    logic [15:0] v;
    v = '0;
    foreach (q[i]) if (i < 16) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    cur.delete();
    bufq.delete();
    have_buf = 0;
    exp_cyc  = 0;
  endtask

  task automatic tick();
    bit exp_stb, exp_ack;
    int n;
    @(negedge clk);
    exp_stb = (cur.size() != 0);
    exp_ack = cyc_i & stb_i & we_i & (qam | qpsk) & !have_buf;
    chk("stb", stb_o, exp_stb);
    chk("we", we_o, exp_stb);
    chk("ack", ack_o, exp_ack);
    chk("cyc", cyc_o, exp_cyc);
    if (exp_stb) begin
      chk("dat", dat_o, cur[0]);
      chk("last", last_o, cur.size() == 1);
    end else begin
      chk("last_idle", last_o, 0);
    end
    last_stb = stb_o;
    last_ack = ack_o;
    last_dat = dat_o;
    if (stb_o && !prev_stb) stb_edges++;
    prev_stb = stb_o;
    if (stb_o && ack_i) begin
      got.push_back(dat_o);
      gotl.push_back(last_o);
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_cyc = cyc_i | have_buf | (cur.size() != 0);
      if (exp_stb && ack_i) void'(cur.pop_front());
      if (have_buf && cur.size() == 0) begin
        cur = bufq;
        have_buf = 0;
      end
      if (exp_ack) begin
        bufq.delete();
        n = qam ? 4 : 2;
        for (int i = 0; i < n; i++) bufq.push_back(dat_i[i]);
        have_buf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(logic [3:0] d);
    int t;
    t = 0;
    cyc_i = 1; stb_i = 1; we_i = 1; dat_i = d;
    do begin
      tick();
      t++;
    end while (!last_ack && t < 20);
    chk("write_ack", last_ack, 1);
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((cur.size() != 0 || have_buf) && t < 64) begin
      tick();
      t++;
    end
    chk("drain_timeout", t < 64, 1);
    tick();
    tick();
  endtask

  task automatic clear_log();
    got.delete();
    gotl.delete();
    stb_edges = 0;
  endtask

  task automatic wait_bits(int n);
    int t;
    t = 0;
    while (got.size() < n && t < 20) begin
      tick();
      t++;
    end
    chk("wait_bits", got.size(), n);
  endtask

  initial begin
    rst_n = 0;
    cyc_i = 0; stb_i = 0; we_i = 0; dat_i = 0;
    qam = 0; qpsk = 0; ack_i = 1;
    prev_stb = 0;
    model_reset();
    clear_log();
    tick();
    tick();
    chk("rst_stb", stb_o, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_dat", dat_o, 0);
    rst_n = 1;
    tick();

    // 1: single QAM symbol, latency and bit order
    qam = 1; qpsk = 0;
    clear_log();
    write_sym(4'b1011);
    tick();
    chk("t1_lat_k", last_stb, 0);
    tick();
    chk("t1_lat_k1", last_stb, 1);
    drain();
    chk("t1_n", got.size(), 4);
    chk("t1_bits", vec(got), 16'b1011);
    chk("t1_last", vec(gotl), 16'b1000);
    chk("t1_idle", last_stb, 0);

    // 2: back-to-back QPSK, unbroken strobe
    qam = 0; qpsk = 1;
    clear_log();
    write_sym(4'b0001);
    write_sym(4'b1110);
    drain();
    chk("t2_n", got.size(), 4);
    chk("t2_bits", vec(got), 16'b1001);
    chk("t2_last", vec(gotl), 16'b1010);
    chk("t2_runs", stb_edges, 1);

    // 3: stall after 2nd bit with second symbol pending
    qam = 1; qpsk = 0;
    clear_log();
    write_sym(4'b0110);
    wait_bits(2);
    ack_i = 0;
    write_sym(4'b1001);
    chk("t3_hold_stb0", last_stb, 1);
    chk("t3_hold_dat0", last_dat, 1);
    cyc_i = 1; stb_i = 1; we_i = 1; dat_i = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_noack", last_ack, 0);
      chk("t3_hold_stb", last_stb, 1);
      chk("t3_hold_dat", last_dat, 1);
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    ack_i = 1;
    drain();
    chk("t3_n", got.size(), 8);
    chk("t3_bits", vec(got), 16'b1001_0110);
    chk("t3_last", vec(gotl), 16'b1000_1000);
    chk("t3_runs", stb_edges, 1);

    // 4: both modes high -> QAM; no mode -> no accept
    qam = 1; qpsk = 1;
    clear_log();
    write_sym(4'b1100);
    drain();
    chk("t4_n", got.size(), 4);
    chk("t4_bits", vec(got), 16'b1100);
    qam = 0; qpsk = 0;
    clear_log();
    cyc_i = 1; stb_i = 1; we_i = 1; dat_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_noack", last_ack, 0);
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    tick();
    tick();
    chk("t4_none", got.size(), 0);

    // 5: QPSK symbol, QAM raised while it is pending
    qam = 0; qpsk = 1;
    clear_log();
    write_sym(4'b1101);
    qam = 1;
    drain();
    chk("t5_n", got.size(), 2);
    chk("t5_bits", vec(got), 16'b01);
    chk("t5_last", vec(gotl), 16'b10);

    // 6: asynchronous reset mid-symbol
    qam = 1; qpsk = 0;
    clear_log();
    write_sym(4'b1111);
    wait_bits(2);
    #2;
    rst_n = 0;
    #1;
    chk("t6_stb", stb_o, 0);
    chk("t6_dat", dat_o, 0);
    chk("t6_last", last_o, 0);
    chk("t6_cyc", cyc_o, 0);
    model_reset();
    clear_log();
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_resid", got.size(), 0);
    write_sym(4'b0101);
    drain();
    chk("t6_n", got.size(), 4);
    chk("t6_bits", vec(got), 16'b0101);

    // random traffic, modes and backpressure
    clear_log();
    for (int i = 0; i < 400; i++) begin
      cyc_i = ($urandom_range(0, 3) != 0);
      stb_i = ($urandom_range(0, 3) != 0);
      we_i  = ($urandom_range(0, 7) != 0);
      dat_i = 4'($urandom_range(0, 15));
      qam   = ($urandom_range(0, 2) == 0);
      qpsk  = ($urandom_range(0, 2) != 0);
      ack_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    cyc_i = 0; stb_i = 0; we_i = 0; ack_i = 1;
    drain();
    chk("rand_empty", stb_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
